if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core, directly upstream of the combinational instruction ROM.
- Owns the PC, selects the next PC (sequential, branch, jump, jr, interrupt vector, exception vector), drives the ROM address, and registers the returned instruction into the IF/ID pipeline register.
- Handles stall, flush, interrupt entry and EPC capture; PC[31] is the kernel-mode bit.

---
 rtl/if_fetch_stage.sv | 97 +++++++++
 tb/tb_if_fetch_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, picks the next fetch address and
// registers the ROM output into the IF/ID pipeline register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_en,
    input  logic [25:0] jump_index,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic        irq,
    input  logic        exception,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] epc,
    output logic        irq_taken
);

    logic [31:0] pc_plus4;
    logic [31:0] jump_addr;
    logic [31:0] next_pc;
    logic        irq_ok;
    logic        flush;
    logic        hold;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    // The jump region comes from the jumping instruction (now in ID), not the fetch PC.
    assign jump_addr = {if_id_pc_plus4[31:28], jump_index, 2'b00};

    // Kernel mode (PC bit 31) on either the fetch or the ID instruction blocks entry.
    assign irq_ok = irq & ~pc[31] & ~if_id_pc_plus4[31] & if_id_valid
                  & ~branch_taken & ~jump_en & ~jr_en & ~stall & ~exception;

    always_comb begin
        next_pc = pc_plus4;
        flush   = 1'b0;
        hold    = 1'b0;
        if (exception) begin
            next_pc = EXC_VEC;
            flush   = 1'b1;
        end else if (branch_taken) begin
            next_pc = branch_target;
            flush   = 1'b1;
        end else if (irq_ok) begin
            next_pc = IRQ_VEC;
            flush   = 1'b1;
        end else if (stall) begin
            next_pc = pc;
            hold    = 1'b1;
        end else if (jr_en) begin
            next_pc = jr_target;
            flush   = 1'b1;
        end else if (jump_en) begin
            next_pc = jump_addr;
            flush   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_VEC;
            if_id_instr    <= 32'd0;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            epc            <= 32'd0;
            irq_taken      <= 1'b0;
        end else begin
            pc        <= next_pc;
            irq_taken <= irq_ok;
            if (irq_ok) begin
                // Return address is the squashed ID instruction so it re-executes.
                epc <= if_id_pc_plus4 - 32'd4;
            end
            if (flush) begin
                if_id_instr    <= 32'd0;
                if_id_pc_plus4 <= 32'd0;
                if_id_valid    <= 1'b0;
            end else if (!hold) begin
                if_id_instr    <= imem_instr;
                if_id_pc_plus4 <= pc_plus4;
                if_id_valid    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios followed by
// randomized control traffic, both compared against a behavioural model.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump_en, jr_en, irq, exception;
    logic [31:0] branch_target, jr_target;
    logic [25:0] jump_index;
    logic [31:0] imem_addr, imem_instr, pc, if_id_instr, if_id_pc_plus4, epc;
    logic        if_id_valid, irq_taken;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ip4;
        logic        valid;
        logic [31:0] epc;
        logic        taken;
    } state_t;

    state_t m;

    always #5 clk = ~clk;

    // Synthetic ROM contents: distinct, address-dependent words.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C1D_5A00;
    endfunction

    assign imem_instr = rom(imem_addr);

    if_fetch_stage #(.RESET_VEC(RESET_VEC), .IRQ_VEC(IRQ_VEC), .EXC_VEC(EXC_VEC)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_en(jump_en), .jump_index(jump_index),
        .jr_en(jr_en), .jr_target(jr_target),
        .irq(irq), .exception(exception),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .pc(pc), .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid(if_id_valid), .epc(epc), .irq_taken(irq_taken)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Next architectural state from the fetch rules, given the current inputs.
    function automatic state_t model_next(input state_t s);
        state_t n;
        logic   take;
        n       = s;
        n.taken = 1'b0;
        if (reset) begin
            n = '{pc: RESET_VEC, instr: 32'd0, ip4: 32'd0, valid: 1'b0, epc: 32'd0, taken: 1'b0};
            return n;
        end
        take = irq && !s.pc[31] && !s.ip4[31] && s.valid && !branch_taken
               && !jump_en && !jr_en && !stall && !exception;
        if (exception || branch_taken || take || (!stall && (jr_en || jump_en))) begin
            n.instr = 32'd0;
            n.ip4   = 32'd0;
            n.valid = 1'b0;
            if (exception)         n.pc = EXC_VEC;
            else if (branch_taken) n.pc = branch_target;
            else if (take) begin
                n.pc    = IRQ_VEC;
                n.epc   = s.ip4 - 32'd4;
                n.taken = 1'b1;
            end
            else if (jr_en)        n.pc = jr_target;
            else                   n.pc = {s.ip4[31:28], jump_index, 2'b00};
        end else if (!stall) begin
            n.pc    = s.pc + 32'd4;
            n.instr = rom(s.pc);
            n.ip4   = s.pc + 32'd4;
            n.valid = 1'b1;
        end
        return n;
    endfunction

    task automatic compareAll();
        checkOutput("pc", pc, m.pc);
        checkOutput("imem_addr", imem_addr, m.pc);
        checkOutput("if_id_instr", if_id_instr, m.instr);
        checkOutput("if_id_pc_plus4", if_id_pc_plus4, m.ip4);
        checkOutput("if_id_valid", {31'd0, if_id_valid}, {31'd0, m.valid});
        checkOutput("epc", epc, m.epc);
        checkOutput("irq_taken", {31'd0, irq_taken}, {31'd0, m.taken});
    endtask

    // Drive one cycle of inputs, advance the model and the DUT, compare everything.
    task automatic applyStimulus(input logic rst, input logic exc, input logic br,
                                 input logic [31:0] bt, input logic st, input logic rq,
                                 input logic jr, input logic [31:0] jt,
                                 input logic j, input logic [25:0] ji);
        reset = rst; exception = exc; branch_taken = br; branch_target = bt;
        stall = st; irq = rq; jr_en = jr; jr_target = jt; jump_en = j; jump_index = ji;
        m = model_next(m);
        @(posedge clk);
        #1;
        compareAll();
    endtask

    task automatic idle(input logic rq);
        applyStimulus(0, 0, 0, 32'd0, 0, rq, 0, 32'd0, 0, 26'd0);
    endtask

    initial begin
        m = '0;
        // Reset and free-run from the reset vector.
        applyStimulus(1, 0, 0, 32'd0, 0, 0, 0, 32'd0, 0, 26'd0);
        checkOutput("reset_pc", pc, 32'h8000_0000);
        checkOutput("reset_valid", {31'd0, if_id_valid}, 32'd0);
        idle(0);
        checkOutput("run_ip4", if_id_pc_plus4, 32'h8000_0004);
        checkOutput("run_valid", {31'd0, if_id_valid}, 32'd1);
        idle(0); idle(0);
        checkOutput("run_pc3", pc, 32'h8000_000C);

        // Branch to 0x68, then a taken branch from there to 0x84.
        applyStimulus(0, 0, 1, 32'h0000_0068, 0, 0, 0, 32'd0, 0, 26'd0);
        checkOutput("br1_pc", pc, 32'h0000_0068);
        applyStimulus(0, 0, 1, 32'h0000_0084, 0, 0, 0, 32'd0, 0, 26'd0);
        checkOutput("br2_pc", pc, 32'h0000_0084);
        checkOutput("br2_valid", {31'd0, if_id_valid}, 32'd0);
        idle(0);
        checkOutput("br_seq_pc", pc, 32'h0000_0088);

        // Jump with index 0x1A from an instruction whose PC+4 is 0x80; stall first.
        applyStimulus(0, 0, 1, 32'h0000_007C, 0, 0, 0, 32'd0, 0, 26'd0);
        idle(0);
        checkOutput("jmp_ip4", if_id_pc_plus4, 32'h0000_0080);
        applyStimulus(0, 0, 0, 32'd0, 1, 0, 0, 32'd0, 1, 26'h1A);
        checkOutput("stall_pc", pc, 32'h0000_0080);
        checkOutput("stall_ip4", if_id_pc_plus4, 32'h0000_0080);
        applyStimulus(0, 0, 0, 32'd0, 0, 0, 0, 32'd0, 1, 26'h1A);
        checkOutput("jmp_pc", pc, 32'h0000_0068);

        // Interrupt from user code, no re-entry while in kernel, return via jr.
        applyStimulus(0, 0, 1, 32'h0000_00D0, 0, 0, 0, 32'd0, 0, 26'd0);
        idle(0);
        idle(1);
        checkOutput("irq_pc", pc, IRQ_VEC);
        checkOutput("irq_epc", epc, 32'h0000_00D0);
        checkOutput("irq_taken", {31'd0, irq_taken}, 32'd1);
        checkOutput("irq_valid", {31'd0, if_id_valid}, 32'd0);
        idle(1); idle(1); idle(1);
        checkOutput("irq_noreentry", {31'd0, irq_taken}, 32'd0);
        applyStimulus(0, 0, 0, 32'd0, 0, 0, 1, 32'h0000_00D0, 0, 26'd0);
        checkOutput("jr_pc", pc, 32'h0000_00D0);

        // Exception beats branch, stall and irq; epc must not move.
        idle(0);
        applyStimulus(0, 1, 1, 32'h0000_0200, 1, 1, 0, 32'd0, 0, 26'd0);
        checkOutput("exc_pc", pc, EXC_VEC);
        checkOutput("exc_epc", epc, 32'h0000_00D0);

        // Reset during a redirect.
        idle(0);
        applyStimulus(1, 0, 1, 32'h0000_0300, 0, 0, 0, 32'd0, 0, 26'd0);
        checkOutput("rst_redirect_pc", pc, RESET_VEC);
        checkOutput("rst_redirect_ip4", if_id_pc_plus4, 32'd0);

        // Randomized traffic; irq is held in runs to mimic a level request.
        begin
            logic rq = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                logic [31:0] bt, jt;
                if ($urandom_range(0, 9) == 0) rq = ~rq;
                bt = {($urandom_range(0, 3) == 0), 19'd0, 12'($urandom)};
                jt = {($urandom_range(0, 3) == 0), 19'd0, 12'($urandom)};
                applyStimulus($urandom_range(0, 199) == 0,
                              $urandom_range(0, 49) == 0,
                              $urandom_range(0, 11) == 0, bt,
                              $urandom_range(0, 6) == 0, rq,
                              $urandom_range(0, 19) == 0, jt,
                              $urandom_range(0, 14) == 0, 26'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
